rr_arbiter8: RTL



---
 rtl/rr_arbiter8_pkg.sv | 28 ++
 rtl/decoder3to8.sv | 14 +
 rtl/rr_arbiter8.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants, FSM state type and the circular winner search
// used by the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [0:0] {
      IDLE,
      GRANT
   } state_t;

   // First set bit of vec, scanning upward from start and wrapping 7 -> 0.
   // Scanning from the far end lets the nearest hit overwrite later ones, so no found flag is needed.
   // Returns 0 when vec is empty; callers only use the result when vec != 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                                input logic [IDX_W-1:0]   start);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] idx;
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = start + IDX_W'(i);
         if (vec[idx]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/decoder3to8.sv
// decoder3to8: binary-to-one-hot decoder.
// Ports:
//   sel  input  [2:0]  binary index
//   dec  output [7:0]  one-hot vector with bit sel set
module decoder3to8 (
   input  logic [2:0] sel,
   output logic [7:0] dec
);

   always_comb begin
      dec = 8'h01 << sel;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with an optional hold limit.
// A grant is held while its owner keeps requesting; after MAX_HOLD consecutive cycles the grant
// is forced onward if anyone else is waiting (MAX_HOLD = 0 disables this).
// Parameters:
//   MAX_HOLD  cycles before forced rotation (0 = never preempt); must be < 2**CNT_W
//   CNT_W     hold counter width
// Ports:
//   clk         input         rising-edge clock
//   reset       input         asynchronous active-high reset
//   req         input  [7:0]  request vector, level-held until done
//   gnt_onehot  output [7:0]  one-hot grant, all zero when no grant
//   gnt_idx     output [2:0]  current owner, meaningful only with gnt_valid
//   gnt_valid   output        a grant is active
//   gnt_new     output        single-cycle pulse on the first cycle of every new grant
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               gnt_new
);

   localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic               gnt_new_q, gnt_new_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] others;
   logic [NUM_REQ-1:0] dec_out;
   logic               take;
   logic [IDX_W-1:0]   win;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         gnt_new_q   <= 1'b0;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_new_q   <= gnt_new_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // The owner's own request never counts as competition.
      owner_mask  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;
      others      = req & ~owner_mask;

      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      gnt_new_d   = 1'b0;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      take        = 1'b0;
      win         = rr_pick(others, gnt_idx_q + IDX_W'(1));

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               take = 1'b1;
               win  = rr_pick(req, ptr_q);
            end
         end
         GRANT: begin
            if (!req[gnt_idx_q]) begin
               if (|others) begin
                  take = 1'b1;
               end else begin
                  gnt_valid_d = 1'b0;
                  hold_cnt_d  = '0;
                  state_d     = IDLE;
               end
            end else if (PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && (|others)) begin
               take = 1'b1;
            end else if (PREEMPT_EN && (hold_cnt_q != HOLD_LAST)) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
      endcase

      // Every grant, fresh or handed over, restarts the hold count and moves the pointer past it.
      if (take) begin
         state_d     = GRANT;
         gnt_idx_d   = win;
         gnt_valid_d = 1'b1;
         gnt_new_d   = 1'b1;
         ptr_d       = win + IDX_W'(1);
         hold_cnt_d  = '0;
      end
   end

   decoder3to8 u_dec (
      .sel (gnt_idx_q),
      .dec (dec_out)
   );

   // Outputs come only from registers, so req changes cannot glitch them.
   always_comb begin
      gnt_onehot = dec_out & {NUM_REQ{gnt_valid_q}};
      gnt_idx    = gnt_idx_q;
      gnt_valid  = gnt_valid_q;
      gnt_new    = gnt_new_q;
   end

endmodule
